// File: rtl/display_scan_mux_pkg.sv
// Shared constants and helpers for the 7-segment scan path.
package display_pkg;

  localparam int BCD_W = 4;
  localparam int MAX_DIGITS = 8;
  localparam logic [BCD_W-1:0] BLANK_NIBBLE = 4'hF;

  // Active-low anodes, so the "all off" pattern is the low n bits set to one.
  function automatic logic [MAX_DIGITS-1:0] an_all_off(input int n);
    logic [MAX_DIGITS-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/display_scan_mux_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_prescaler #(
  parameter int DIV = 50000,
  parameter int W   = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/display_scan_mux.sv
// Multi-digit time-multiplexer with double-buffered digits.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_MUX_LZB_EN.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BCD_W*N_DIGITS-1:0] digits_in,
  input  logic                      load,
  output logic [BCD_W-1:0]          digit_out,
  output logic [N_DIGITS-1:0]       an,
  output logic                      frame_start
);

  localparam int DATA_W = BCD_W * N_DIGITS;
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [MAX_DIGITS-1:0] AN_OFF_FULL = an_all_off(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_OFF = AN_OFF_FULL[N_DIGITS-1:0];
`ifdef DISPLAY_SCAN_MUX_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  logic                  adv;
  logic                  wrap;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     pending_q;
  logic [DATA_W-1:0]     display_q, display_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [BCD_W-1:0]      digit_q, digit_d;
  logic                  frameStart_q;
  logic                  zeroAbove;
  logic                  blank;

  tick_prescaler #(
    .DIV (REFRESH_DIV),
    .W   (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (adv)
  );

  // Slot outputs are derived from the buffer as it will be after this edge, so a
  // wrapping edge (including a coinciding load) shows the new frame immediately.
  always_comb begin
    idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    wrap      = adv && (idx_q == LAST_IDX);
    display_d = display_q;
    if (wrap) display_d = load ? digits_in : pending_q;

    zeroAbove = 1'b1;
    blank     = 1'b0;
    digit_d   = BLANK_NIBBLE;
    an_d      = AN_OFF;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zeroAbove = zeroAbove & (display_d[i*BCD_W +: BCD_W] == '0);
      if (IDX_W'(i) == idx_d) begin
        digit_d = display_d[i*BCD_W +: BCD_W];
        an_d[i] = 1'b0;
        blank   = LZB_EN && zeroAbove && (i != 0);
      end
    end
    if (blank) begin
      digit_d = BLANK_NIBBLE;
      an_d    = AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      display_q    <= '0;
      idx_q        <= LAST_IDX;
      an_q         <= AN_OFF;
      digit_q      <= BLANK_NIBBLE;
      frameStart_q <= 1'b0;
    end else begin
      if (load) pending_q <= digits_in;
      display_q    <= display_d;
      frameStart_q <= wrap;
      if (adv) begin
        idx_q   <= idx_d;
        an_q    <= an_d;
        digit_q <= digit_d;
      end
    end
  end

  assign digit_out   = digit_q;
  assign an          = an_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux (N_DIGITS=4, REFRESH_DIV=4); honours DISPLAY_SCAN_MUX_LZB_EN.
module tb_display_scan_mux;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digitsIn;
  logic [3:0]  digitOut;
  logic [3:0]  an;
  logic        frameStart;

  int checks   = 0;
  int failures = 0;

  // Model state: mt counts edges since the last reset edge
  int          mt     = 0;
  bit          mValid = 1'b0;
  logic [15:0] mPend  = '0;
  logic [15:0] mFrame = '0;
  logic [15:0] mEff;
  logic [3:0]  eDigit = 4'hF;
  logic [3:0]  eAn    = 4'hF;
  logic        eFs    = 1'b0;
  int          slot;

  display_scan_mux #(
    .N_DIGITS    (4),
    .REFRESH_DIV (4),
    .DIV_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digitsIn),
    .load        (load),
    .digit_out   (digitOut),
    .an          (an),
    .frame_start (frameStart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at t=%0d: got %h, expected %h", name, mt, act, exp);
    end
  endtask

  // Slot timing from the spec: slot k starts 4*(k+1) edges after reset, digit k%4,
  // and the frame value is whatever pending holds at the start of slot 0 (load bypasses).
  always @(posedge clk) begin
    if (rst) begin
      mt = 0; mValid = 1'b1; mPend = '0; mFrame = '0;
      eDigit = 4'hF; eAn = 4'hF; eFs = 1'b0;
    end else if (mValid) begin
      mt++;
      mEff = load ? digitsIn : mPend;
      if (load) mPend = digitsIn;
      eFs = 1'b0;
      if (mt >= 4 && mt % 4 == 0) begin
        slot = (mt / 4 - 1) % 4;
        if (slot == 0) begin
          mFrame = mEff;
          eFs = 1'b1;
        end
        eDigit = 4'((mFrame >> (4 * slot)) & 16'hF);
        eAn    = 4'b1111 & ~(4'b0001 << slot);
`ifdef DISPLAY_SCAN_MUX_LZB_EN
        if (slot >= 1 && (mFrame >> (4 * slot)) == 16'h0) begin
          eDigit = 4'hF;
          eAn    = 4'hF;
        end
`endif
      end
    end
    #1;
    if (mValid) begin
      checkEq("model_digit", digitOut, eDigit);
      checkEq("model_an", an, eAn);
      checkEq("model_fs", {3'b000, frameStart}, {3'b000, eFs});
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] expDigit,
                             input logic [3:0] expAn, input logic expFs);
    checkEq({name, "_digit"}, digitOut, expDigit);
    checkEq({name, "_an"}, an, expAn);
    checkEq({name, "_fs"}, {3'b000, frameStart}, {3'b000, expFs});
  endtask

  task automatic applyStimulus(input logic doLoad, input logic [15:0] value);
    load     = doLoad;
    digitsIn = value;
  endtask

  task automatic waitT(input int n);
    int guard = 0;
    while (mt < n && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (mt < n) begin
      checks++;
      failures++;
      $display("[TB] FAIL waitT timeout: reached t=%0d, expected t=%0d", mt, n);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    applyStimulus(1'b1, 16'h1234);
    waitT(1);
    applyStimulus(1'b0, 16'h0000);

    waitT(3);  checkOutput("idle",     4'hF, 4'b1111, 1'b0);
    waitT(4);  checkOutput("first",    4'h4, 4'b1110, 1'b1);
    waitT(5);  checkOutput("fsDrop",   4'h4, 4'b1110, 1'b0);
    waitT(8);  checkOutput("slot1",    4'h3, 4'b1101, 1'b0);
    waitT(12); checkOutput("slot2",    4'h2, 4'b1011, 1'b0);
    waitT(16); checkOutput("slot3",    4'h1, 4'b0111, 1'b0);
    waitT(20); checkOutput("frame2",   4'h4, 4'b1110, 1'b1);

    waitT(25); applyStimulus(1'b1, 16'h5678);
    waitT(26); applyStimulus(1'b0, 16'h0000);
    waitT(28); checkOutput("midOld2",  4'h2, 4'b1011, 1'b0);
    waitT(32); checkOutput("midOld3",  4'h1, 4'b0111, 1'b0);
    waitT(36); checkOutput("new0",     4'h8, 4'b1110, 1'b1);
    waitT(40); checkOutput("new1",     4'h7, 4'b1101, 1'b0);
    waitT(44); checkOutput("new2",     4'h6, 4'b1011, 1'b0);
    waitT(48); checkOutput("new3",     4'h5, 4'b0111, 1'b0);

    waitT(51); applyStimulus(1'b1, 16'h9999);
    waitT(52); applyStimulus(1'b0, 16'h0000);
    checkOutput("bypass0", 4'h9, 4'b1110, 1'b1);
    waitT(56); checkOutput("bypass1",  4'h9, 4'b1101, 1'b0);
    waitT(64); checkOutput("bypass3",  4'h9, 4'b0111, 1'b0);

    waitT(77); rst = 1'b1;
    @(posedge clk); #2;
    checkOutput("rstNow", 4'hF, 4'b1111, 1'b0);
    rst = 1'b0;
    waitT(3);  checkOutput("rstIdle",  4'hF, 4'b1111, 1'b0);
    waitT(4);  checkOutput("rstFirst", 4'h0, 4'b1110, 1'b1);

    waitT(5);  applyStimulus(1'b1, 16'h0040);
    waitT(6);  applyStimulus(1'b0, 16'h0000);
    waitT(20); checkOutput("lz0",      4'h0, 4'b1110, 1'b1);
    waitT(24); checkOutput("lz1",      4'h4, 4'b1101, 1'b0);
`ifdef DISPLAY_SCAN_MUX_LZB_EN
    waitT(28); checkOutput("lz2",      4'hF, 4'b1111, 1'b0);
    waitT(32); checkOutput("lz3",      4'hF, 4'b1111, 1'b0);
`else
    waitT(28); checkOutput("lz2",      4'h0, 4'b1011, 1'b0);
    waitT(32); checkOutput("lz3",      4'h0, 4'b0111, 1'b0);
`endif
    waitT(33); applyStimulus(1'b1, 16'h0000);
    waitT(34); applyStimulus(1'b0, 16'h0000);
    waitT(36); checkOutput("zero0",    4'h0, 4'b1110, 1'b1);
`ifdef DISPLAY_SCAN_MUX_LZB_EN
    waitT(40); checkOutput("zero1",    4'hF, 4'b1111, 1'b0);
`else
    waitT(40); checkOutput("zero1",    4'h0, 4'b1101, 1'b0);
`endif
    waitT(44);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
